// File: rtl/rsa_seq_if.sv
// Job/config and array-control bundle between a job source (master) and rsa_seq_ctrl (slave).
// RSA_SEQ_ABORT_EN adds the abort request and the aborted status pulse.
interface rsa_seq_if #(
  parameter int X   = 4,
  parameter int Y   = 4,
  parameter int K_W = 8
);
  logic             start;
  logic [1:0]       cfg_pe_mode;
  logic [K_W-1:0]   cfg_k;
  logic [1:0]       cfg_m_add;
  logic             busy;
  logic             done;
  logic [1:0]       PE_mode;
  logic [Y-1:0]     new_cal_en;
  logic [Y-1:0]     new_cal_done;
  logic [2*X-1:0]   M_adder_mode;
  logic             b_rd_en;
  logic [K_W-1:0]   b_rd_idx;
`ifdef RSA_SEQ_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (
    output start, cfg_pe_mode, cfg_k, cfg_m_add, abort,
    input  busy, done, PE_mode, new_cal_en, new_cal_done, M_adder_mode,
           b_rd_en, b_rd_idx, aborted
  );
  modport slave (
    input  start, cfg_pe_mode, cfg_k, cfg_m_add, abort,
    output busy, done, PE_mode, new_cal_en, new_cal_done, M_adder_mode,
           b_rd_en, b_rd_idx, aborted
  );
`else
  modport master (
    output start, cfg_pe_mode, cfg_k, cfg_m_add,
    input  busy, done, PE_mode, new_cal_en, new_cal_done, M_adder_mode,
           b_rd_en, b_rd_idx
  );
  modport slave (
    input  start, cfg_pe_mode, cfg_k, cfg_m_add,
    output busy, done, PE_mode, new_cal_en, new_cal_done, M_adder_mode,
           b_rd_en, b_rd_idx
  );
`endif
endinterface

// File: rtl/rsa_seq_ctrl.sv
// Job sequencer for the XxY systolic PE array: skewed column enables, operand reads, drain, done.
// Define RSA_SEQ_ABORT_EN to add the abort input / aborted pulse.
//
//   state   | meaning
//   S_IDLE  | waiting for start; cfg captured on the accepting edge
//   S_LOAD  | one cycle; K==0 jobs skip straight to S_DONE
//   S_FEED  | t = 0..K+Y-2, skewed per-column enables and operand reads
//   S_DRAIN | DRAIN_CYC cycles for array and adder pipelines to empty
//   S_DONE  | one-cycle done pulse
module rsa_seq_ctrl #(
  parameter int X       = 4,
  parameter int Y       = 4,
  parameter int K_W     = 8,
  parameter int ADD_LAT = 1
) (
  input  logic       clk,
  input  logic       sys_rst,
  rsa_seq_if.slave   bus
);
  localparam int DRAIN_CYC = X + Y + ADD_LAT;
  localparam int TW        = K_W + 1;
  localparam int DW        = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic [K_W-1:0] k_q;
  logic [1:0]     pe_mode_q;
  logic [1:0]     m_add_q;
  logic           accept;
  logic           abort_req;
  logic [TW-1:0]  k_ext;
  logic [TW-1:0]  feed_last;
  logic           feeding;
  logic [Y-1:0]   cal_en;
  logic [Y-1:0]   cal_done;

  assign accept    = (state_q == S_IDLE) && bus.start;
  assign k_ext     = {1'b0, k_q};
  assign feed_last = k_ext + TW'(Y - 2);
  assign feeding   = (state_q == S_FEED);

`ifdef RSA_SEQ_ABORT_EN
  logic aborted_q;

  assign abort_req = bus.abort && (state_q inside {S_LOAD, S_FEED, S_DRAIN});

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) aborted_q <= 1'b0;
    else          aborted_q <= abort_req;
  end

  assign bus.aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      drain_q   <= '0;
      k_q       <= '0;
      pe_mode_q <= '0;
      m_add_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drain_q <= drain_d;
      if (accept) begin
        k_q       <= bus.cfg_k;
        pe_mode_q <= bus.cfg_pe_mode;
        m_add_q   <= bus.cfg_m_add;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = '0;
    drain_d = '0;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = (k_q == '0) ? S_DONE : S_FEED;
      S_FEED: begin
        if (t_q == feed_last) begin
          state_d = S_DRAIN;
          drain_d = DW'(DRAIN_CYC - 1);
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_req) begin
      state_d = S_IDLE;
      t_d     = '0;
      drain_d = '0;
    end
  end

  // Column p sees logical step t-j, j being its distance from the feeding edge.
  for (genvar p = 0; p < Y; p++) begin : g_col
    logic [TW-1:0] j;
    logic [TW-1:0] diff;
    assign j           = pe_mode_q[0] ? TW'(Y - 1 - p) : TW'(p);
    assign diff        = t_q - j;
    assign cal_en[p]   = feeding && (t_q >= j) && (diff < k_ext);
    assign cal_done[p] = feeding && (t_q >= j) && (diff == k_ext - TW'(1));
  end

  assign bus.busy         = state_q inside {S_LOAD, S_FEED, S_DRAIN};
  assign bus.done         = (state_q == S_DONE);
  assign bus.PE_mode      = pe_mode_q;
  assign bus.new_cal_en   = cal_en;
  assign bus.new_cal_done = cal_done;
  assign bus.M_adder_mode = (state_q inside {S_FEED, S_DRAIN}) ? {X{m_add_q}} : '0;
  assign bus.b_rd_en      = feeding && (t_q < k_ext);
  assign bus.b_rd_idx     = bus.b_rd_en ? t_q[K_W-1:0] : '0;
endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Bench for rsa_seq_ctrl: job-timeline reference model checked every cycle, directed
// literal checks from the known timing, then randomized jobs, resets and aborts.
module tb_rsa_seq_ctrl;
  localparam int X = 4, Y = 4, K_W = 8, ADD_LAT = 1;
  localparam int DR = X + Y + ADD_LAT;
  localparam int MAXC = 16384;

  logic clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 clk = ~clk;

  rsa_seq_if #(.X(X), .Y(Y), .K_W(K_W)) bus();
  rsa_seq_ctrl #(.X(X), .Y(Y), .K_W(K_W), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .sys_rst(sys_rst), .bus(bus));

  logic abort_in;
  logic abd_out;
`ifdef RSA_SEQ_ABORT_EN
  assign abort_in = bus.abort;
  assign abd_out  = bus.aborted;
`else
  assign abort_in = 1'b0;
  assign abd_out  = 1'b0;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // observation logs used by the directed literal checks
  logic [Y-1:0] en_log [MAXC];
  logic [1:0]   pe_log [MAXC];
  int done_cnt = 0, last_done = -1, abd_cnt = 0, last_abd = -1, act_cnt = 0;

  // reference model: one job timeline relative to its accept cycle
  bit m_act = 0, m_abd = 0, nxt;
  int m_c0, m_k, m_end, r, t, jj;
  logic [1:0] m_mode, m_madd, m_pe = '0;
  logic e_busy, e_done, e_rd, e_abd;
  logic [Y-1:0] e_en, e_cd;
  logic [2*X-1:0] e_ma;
  logic [K_W-1:0] e_idx;
  logic [1:0] e_pe;

  always @(negedge clk) begin
    e_busy = 0; e_done = 0; e_rd = 0; e_en = '0; e_cd = '0; e_ma = '0;
    e_idx = '0; e_pe = '0; e_abd = 0;
    if (sys_rst) begin
      e_pe = m_pe;
      e_abd = m_abd;
      if (m_act) begin
        r = cyc - m_c0;
        e_busy = (r < m_end);
        e_done = (r == m_end);
        if (m_k > 0 && r >= 2 && r < m_end) e_ma = {X{m_madd}};
        if (m_k > 0 && r >= 2 && r <= m_k + Y) begin
          t = r - 2;
          for (int p = 0; p < Y; p++) begin
            jj = m_mode[0] ? Y - 1 - p : p;
            if (t >= jj && t - jj < m_k) e_en[p] = 1'b1;
            if (t - jj == m_k - 1) e_cd[p] = 1'b1;
          end
          if (t < m_k) begin e_rd = 1; e_idx = K_W'(t); end
        end
      end
    end
    chk("busy", bus.busy, e_busy);
    chk("done", bus.done, e_done);
    chk("PE_mode", bus.PE_mode, e_pe);
    chk("new_cal_en", bus.new_cal_en, e_en);
    chk("new_cal_done", bus.new_cal_done, e_cd);
    chk("M_adder_mode", bus.M_adder_mode, e_ma);
    chk("b_rd_en", bus.b_rd_en, e_rd);
    chk("b_rd_idx", bus.b_rd_idx, e_idx);
`ifdef RSA_SEQ_ABORT_EN
    chk("aborted", abd_out, e_abd);
`endif
    if (cyc < MAXC) begin en_log[cyc] = bus.new_cal_en; pe_log[cyc] = bus.PE_mode; end
    if (bus.done) begin done_cnt++; last_done = cyc; end
    if (abd_out) begin abd_cnt++; last_abd = cyc; end
    if (bus.b_rd_en || bus.new_cal_en != '0) act_cnt++;
    if (!sys_rst) begin
      m_act = 0; m_pe = '0; m_abd = 0;
    end else begin
      nxt = 0;
      if (m_act) begin
        r = cyc - m_c0;
        if (abort_in && r < m_end) begin m_act = 0; nxt = 1; end
        else if (r == m_end) m_act = 0;
      end else if (bus.start) begin
        m_act = 1; m_c0 = cyc; m_k = int'(bus.cfg_k);
        m_mode = bus.cfg_pe_mode; m_madd = bus.cfg_m_add; m_pe = bus.cfg_pe_mode;
        m_end = (m_k == 0) ? 2 : m_k + Y + DR + 1;
      end
      m_abd = nxt;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic launch(int k, logic [1:0] mode, logic [1:0] madd, output int s);
    bus.start = 1; bus.cfg_k = K_W'(k); bus.cfg_pe_mode = mode; bus.cfg_m_add = madd;
    s = cyc;
    step();
    bus.start = 0;
  endtask

  task automatic wait_done(int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin step(); n++; end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < budget) begin step(); n++; end
    chk("idle_reached", bus.busy || bus.done, 0);
  endtask

  int s, d0, a0;
  bit prev_start;
  initial begin
    bus.start = 0; bus.cfg_k = '0; bus.cfg_pe_mode = '0; bus.cfg_m_add = '0;
`ifdef RSA_SEQ_ABORT_EN
    bus.abort = 0;
`endif
    step(3);
    sys_rst = 1;
    step(2);

    // K=4, W_2_E / N_2_S
    launch(4, 2'b00, 2'b10, s);
    wait_done(60);
    chk("lit_done_k4", last_done - s, 18);
    chk("lit_en0_c1", en_log[s+1][0], 0);
    chk("lit_en0_c2", en_log[s+2][0], 1);
    chk("lit_en0_c6", en_log[s+6][0], 0);
    chk("lit_en3_c4", en_log[s+4][3], 0);
    chk("lit_en3_c5", en_log[s+5][3], 1);
    chk("lit_en3_c8", en_log[s+8][3], 1);
    chk("lit_en3_c9", en_log[s+9][3], 0);
    step(2);

    // K=4, E_2_W
    launch(4, 2'b01, 2'b01, s);
    wait_done(60);
    chk("lit_done_e2w", last_done - s, 18);
    chk("lit_e2w_en3_c2", en_log[s+2][3], 1);
    chk("lit_e2w_en0_c4", en_log[s+4][0], 0);
    chk("lit_e2w_en0_c5", en_log[s+5][0], 1);
    chk("lit_e2w_en0_c8", en_log[s+8][0], 1);
    chk("lit_pe_c0", pe_log[s], 2'b00);
    chk("lit_pe_c1", pe_log[s+1], 2'b01);
    step(3);
    chk("lit_pe_hold", bus.PE_mode, 2'b01);

    // K=0
    a0 = act_cnt;
    launch(0, 2'b10, 2'b11, s);
    wait_done(20);
    chk("lit_done_k0", last_done - s, 2);
    chk("lit_k0_no_feed", act_cnt - a0, 0);
    step(2);

    // start during FEED is ignored
    d0 = done_cnt;
    launch(4, 2'b00, 2'b01, s);
    step(3);
    bus.start = 1; bus.cfg_k = 8'd1; bus.cfg_pe_mode = 2'b11;
    step();
    bus.start = 0;
    step(30);
    chk("lit_single_done", done_cnt - d0, 1);
    chk("lit_done_ign", last_done - s, 18);

    // reset mid-FEED
    d0 = done_cnt;
    launch(4, 2'b00, 2'b01, s);
    step(4);
    sys_rst = 0;
    step(2);
    sys_rst = 1;
    step(25);
    chk("lit_rst_no_done", done_cnt - d0, 0);
    chk("lit_rst_en_before", en_log[s+4], 4'b0111);
    chk("lit_rst_en_at", en_log[s+5], 4'b0000);
    launch(4, 2'b00, 2'b01, s);
    wait_done(60);
    chk("lit_rst_rerun", last_done - s, 18);
    step(2);

    // largest K: t must not wrap
    launch(255, 2'b10, 2'b10, s);
    wait_done(400);
    chk("lit_done_kmax", last_done - s, 255 + Y + DR + 1);
    step(2);

`ifdef RSA_SEQ_ABORT_EN
    d0 = done_cnt;
    launch(4, 2'b00, 2'b01, s);
    step(5);
    bus.abort = 1;
    step();
    bus.abort = 0;
    step(25);
    chk("lit_abort_cyc", last_abd - s, 7);
    chk("lit_abort_en", en_log[s+7], 0);
    chk("lit_abort_no_done", done_cnt - d0, 0);
`endif

    // randomized phase
    prev_start = 0;
    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      if (!prev_start && $urandom_range(0, 1) == 1) begin
        bus.cfg_k = ($urandom_range(0, 3) == 0) ? 8'd0 :
                    ($urandom_range(0, 19) == 0) ? 8'd40 : K_W'($urandom_range(1, 12));
        bus.cfg_pe_mode = 2'($urandom_range(0, 3));
        bus.cfg_m_add   = 2'($urandom_range(0, 3));
      end
      sys_rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
`ifdef RSA_SEQ_ABORT_EN
      bus.abort = ($urandom_range(0, 39) == 0);
`endif
      prev_start = bus.start;
      step();
    end
    bus.start = 0;
    sys_rst = 1;
`ifdef RSA_SEQ_ABORT_EN
    bus.abort = 0;
`endif
    wait_idle(400);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
